fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between instruction memory and the decode stage of the RV32I core. Captures each fetched {PC, instruction} pair in a small circular buffer so fetch keeps running while decode stalls. Presents the oldest entry to decode through a valid/ready handshake. A redirect (branch, jump or trap) empties the queue in one cycle.

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `XLEN`, default 32: width of PC and instruction.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `flush` input, 1 bit: discard all entries (redirect).
- `in_valid` input, 1 bit: fetch presents a pair.
- `in_ready` output, 1 bit: queue can accept a pair.
- `in_pc` input, XLEN bits: PC of the fetched instruction.
- `in_instr` input, XLEN bits: instruction word from instruction memory.
- `out_valid` output, 1 bit: head entry is valid.
- `out_ready` input, 1 bit: decode consumes the head.
- `out_pc` output, XLEN bits: PC of the head entry.
- `out_instr` output, XLEN bits: instruction of the head entry.
- `out_illegal` output, 1 bit: head instruction has `instr[1:0] != 2'b11` (not a 32-bit encoding).
- `count` output, clog2(DEPTH)+1 bits: number of occupied entries.

## Operation
- Storage is DEPTH entries of {pc, instr}, with write pointer, read pointer and occupancy count.
- Push happens when `in_valid && in_ready && !flush`: the entry is written at the write pointer, which then advances.
- Pop happens when `out_valid && out_ready && !flush`: the read pointer advances.
- Pointers wrap modulo DEPTH.
- Count update:
  - count+1 on push only.
  - count-1 on pop only.
  - Unchanged on simultaneous push and pop.
- `in_ready` is `count != DEPTH`. It has no combinational dependence on `out_ready`, so a full queue does not accept a push even while popping.
- `out_valid` is `count != 0`.
- Outputs when empty: `out_pc` is 0, `out_instr` is the NOP `32'h00000013`, and `out_illegal` is 0.
- Outputs when not empty: `out_pc` and `out_instr` are the entry at the read pointer, read combinationally from registers.
- `out_illegal` is decoded combinationally from the head `out_instr`, and only while `out_valid` is 1.
- Flush: on the next edge both pointers and count go to 0. Any push or pop in the flush cycle is ignored.
- Reset (`rst` low):
  - Immediately, independent of clk: pointers and count go to 0 and storage goes to 0.
  - Outputs therefore become: `in_ready` 1, `out_valid` 0, `out_pc` 0, `out_instr` NOP, `count` 0.
  - Reset mid-operation drops all entries.

## Timing
- Latency: an entry pushed at edge N is visible at the head by edge N+1 if the queue was empty. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle in steady state when 0 < count < DEPTH.
- Full (count=DEPTH): `in_ready` is 0. A pop that cycle makes `in_ready` 1 in the following cycle.
- Empty: a pop request is ignored because `out_valid` is 0, and count never underflows.
- Fetch must hold `in_pc`/`in_instr` stable while `in_valid && !in_ready`. Decode need not hold `out_ready`.
- Flush has priority over push and pop. The cycle after a flush, `out_valid` is 0 and `in_ready` is 1.
- Release of `rst` is synchronised externally. The first push is accepted on the first edge with `rst` high.

## Structure
- Shared package `rv32_pkg` holds:
  - `XLEN`.
  - `NOP_INSTR = 32'h00000013`.
  - `INSTR_LEN32 = 2'b11`.
  - The typedef `fetch_pkt_t` = {pc, instr}, reused by the future IF/ID register.
- No sub-module. Pointer, count and storage logic are inline; the expected implementation is 120–200 lines.
- Top-level integration:
  - Instruction memory RD feeds `in_instr`; the PC register feeds `in_pc`.
  - PC advance is gated by `in_ready` and will be replaced by the branch target on `flush`.

## Test plan
- **Reset:** assert `rst`=0 mid-stream holding 2 entries → same cycle `count`=0, `out_valid`=0, `out_instr`=32'h00000013, `in_ready`=1.
- **Fill to full:** push PCs 0x0, 0x4, 0x8, 0xC with instrs 0x00500093, 0x00A00113, 0x002081B3, 0x00000013, `out_ready`=0 → `count`=4, `in_ready`=0. A fifth push of 0x10 is not accepted and the head stays at PC 0x0.
- **Drain in order:** from full, hold `out_ready`=1 → heads 0x0, 0x4, 0x8, 0xC on consecutive cycles, then `out_valid`=0 with `count`=0.
- **Streaming and wrap-around:** continuous push and pop for 10 pairs starting from count 1 → `count` stays 1, output order matches input order across pointer wrap, no entry lost or duplicated.
- **Flush:** with 3 entries, assert `flush` together with `in_valid` (PC 0x20) and `out_ready` → next cycle `count`=0, `out_valid`=0, and PC 0x20 is never presented.
- **Illegal flag:** push instr 0x00000001 at PC 0x40 → when at head, `out_illegal`=1. Push 0x00000013 → `out_illegal`=0. Empty queue → `out_illegal`=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I core definitions.
//   XLEN         - architectural register / PC width
//   NOP_INSTR    - canonical NOP (addi x0, x0, 0), presented when no entry is valid
//   INSTR_LEN32  - low two opcode bits that mark a 32-bit encoding
//   fetch_pkt_t  - {pc, instr} pair carried from fetch towards decode
//   is_len32     - true when an instruction word uses the 32-bit encoding
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [1:0]  INSTR_LEN32 = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic is_len32(input logic [1:0] opc_lo);
    return (opc_lo == INSTR_LEN32);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {pc, instr} pairs between instruction
// memory and decode, so fetch keeps running while decode stalls.
// Ports:
//   clk, rst                 - clock; asynchronous active-low reset
//   flush                    - redirect: drop every entry on the next edge
//   in_valid/in_ready        - fetch-side handshake, with in_pc/in_instr
//   out_valid/out_ready      - decode-side handshake for the head entry
//   out_pc/out_instr         - head entry (0 / NOP when the queue is empty)
//   out_illegal              - head instruction is not a 32-bit encoding
//   count                    - number of occupied entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = rv32_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  import rv32_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_mem_r    [DEPTH];
  logic [XLEN-1:0]  instr_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  logic in_ready_s;
  logic out_valid_s;
  logic push_s;
  logic pop_s;
  logic [XLEN-1:0] out_pc_s;
  logic [XLEN-1:0] out_instr_s;
  logic            out_illegal_s;

  // Handshake qualification; flush suppresses both sides in its cycle.
  always_comb begin
    in_ready_s  = (count_r != CNT_W'(DEPTH));
    out_valid_s = (count_r != {CNT_W{1'b0}});
    push_s      = in_valid && in_ready_s && !flush;
    pop_s       = out_valid_s && out_ready && !flush;
  end

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; cleared on reset so stale pairs never reappear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {XLEN{1'b0}};
        instr_mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= in_pc;
      instr_mem_r[wr_ptr_r] <= in_instr;
    end
  end

  // Head presentation: NOP at PC 0 when empty, illegal flag only for a valid head.
  always_comb begin
    out_pc_s      = {XLEN{1'b0}};
    out_instr_s   = XLEN'(NOP_INSTR);
    out_illegal_s = 1'b0;
    if (out_valid_s) begin
      out_pc_s      = pc_mem_r[rd_ptr_r];
      out_instr_s   = instr_mem_r[rd_ptr_r];
      out_illegal_s = !is_len32(instr_mem_r[rd_ptr_r][1:0]);
    end else begin
      out_pc_s      = {XLEN{1'b0}};
      out_instr_s   = XLEN'(NOP_INSTR);
      out_illegal_s = 1'b0;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign out_pc      = out_pc_s;
  assign out_instr   = out_instr_s;
  assign out_illegal = out_illegal_s;
  assign count       = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. Accepted pushes are
// queued as expected heads; every cycle the head, handshake outputs and
// count are compared against the queue contents.
module tb_fetch_queue;
  import rv32_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_illegal;
  logic [CW-1:0]   count;

  fetch_pkt_t sb[$];
  int n_cmp;
  int n_err;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_illegal(out_illegal), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare state at the falling edge, then advance the model for the
  // handshake that the coming rising edge performs.
  task automatic step();
    int sz;
    bit do_pop;
    bit do_push;
    fetch_pkt_t p;
    @(negedge clk);
    sz = sb.size();
    check("count", 64'(count), 64'(sz));
    check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    if (sz != 0) begin
      check("head_pc", 64'(out_pc), 64'(sb[0].pc));
      check("head_instr", 64'(out_instr), 64'(sb[0].instr));
      check("head_illegal", 64'(out_illegal), 64'(sb[0].instr[1:0] != 2'b11));
    end else begin
      check("empty_pc", 64'(out_pc), 64'd0);
      check("empty_instr", 64'(out_instr), 64'h13);
      check("empty_illegal", 64'(out_illegal), 64'd0);
    end
    do_pop  = (sz != 0) && out_ready && !flush;
    do_push = in_valid && (sz != DEPTH) && !flush;
    if (flush) begin
      sb.delete();
    end else begin
      if (do_pop) p = sb.pop_front();
      if (do_push) begin
        p.pc    = in_pc;
        p.instr = in_instr;
        sb.push_back(p);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                       input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    step();
  endtask

  logic [XLEN-1:0] fill_ins [4];

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    fill_ins[0] = 32'h0050_0093; fill_ins[1] = 32'h00A0_0113;
    fill_ins[2] = 32'h0020_81B3; fill_ins[3] = 32'h0000_0013;

    // Reset state
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'h13);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Fill to full, then a rejected fifth push
    for (int i = 0; i < 4; i++) drive(1'b1, XLEN'(i * 4), fill_ins[i], 1'b0);
    drive(1'b1, 32'h10, 32'h0000_0013, 1'b0);
    drive(1'b1, 32'h10, 32'h0000_0013, 1'b0);
    check("full_head_pc", 64'(out_pc), 64'h0);
    check("full_count", 64'(count), 64'd4);

    // Drain in order, plus one pop request on empty
    for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, 1'b1);

    // Streaming across pointer wrap, count stays 1
    drive(1'b1, 32'h100, 32'h0000_0093, 1'b0);
    for (int i = 1; i <= 10; i++) drive(1'b1, XLEN'(32'h100 + i * 4), XLEN'(32'h0000_0093 + (i << 7)), 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) drive(1'b1, XLEN'(32'h200 + i * 4), 32'h0000_0013, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h20, 32'h0000_0013, 1'b1);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    drive(1'b0, '0, '0, 1'b1);

    // Illegal flag
    drive(1'b1, 32'h40, 32'h0000_0001, 1'b0);
    drive(1'b1, 32'h44, 32'h0000_0013, 1'b0);
    check("illegal_head", 64'(out_illegal), 64'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1);

    // Reset mid-stream holding two entries
    drive(1'b1, 32'h300, 32'h0000_0013, 1'b0);
    drive(1'b1, 32'h304, 32'h0000_0013, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_instr", 64'(out_instr), 64'h13);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 32'h400, 32'h0000_0033, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
